// File: rtl/exception_ctrl_if.sv
// Exception controller bus: retire-side inputs from the pipeline and the
// PC-steering / handler-status outputs back to it.
//   master : pipeline side (drives instr_done, illegal, eret, irq, pc_cur, pc_next)
//   slave  : exception_ctrl side (drives illop, xadr, epc, cause, irq_pending,
//            in_handler, double_fault, exc_count)
interface exception_ctrl_if;
    logic        instr_done;
    logic        illegal;
    logic        eret;
    logic        irq;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        illop;
    logic        xadr;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        irq_pending;
    logic        in_handler;
    logic        double_fault;
    logic [15:0] exc_count;

    modport master (
        output instr_done, illegal, eret, irq, pc_cur, pc_next,
        input  illop, xadr, epc, cause, irq_pending, in_handler, double_fault, exc_count
    );

    modport slave (
        input  instr_done, illegal, eret, irq, pc_cur, pc_next,
        output illop, xadr, epc, cause, irq_pending, in_handler, double_fault, exc_count
    );
endinterface

// File: rtl/exception_ctrl.sv
// Exception controller: detects illegal-opcode retires and external interrupts,
// steers the PC register to the matching vector, saves the return address and
// cause, and tracks handler state.
// Ports:
//   clk   - system clock, all state updates on posedge
//   reset - synchronous active-high reset
//   bus   - exception_ctrl_if.slave (retire inputs, PC-steering and status outputs)
module exception_ctrl (
    input  logic              clk,
    input  logic              reset,
    exception_ctrl_if.slave   bus
);
    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_IRQ  = 2'b10;

    state_t      state;
    logic        irq_q;
    logic        irq_pending;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        double_fault;
    logic [15:0] exc_count;

    logic illop;
    logic xadr;
    logic irq_rise;
    logic eret_retire;

    // Vector-load strobes are forced low during reset so the PC register never
    // jumps to a vector while the block is being cleared.
    always_comb begin
        illop       = !reset && bus.instr_done && bus.illegal;
        xadr        = !reset && bus.instr_done && !bus.illegal && !bus.eret &&
                      irq_pending && !bus.pc_cur[31] && (state == NORMAL);
        irq_rise    = bus.irq && !irq_q;
        eret_retire = bus.instr_done && bus.eret && !bus.illegal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= NORMAL;
            irq_q        <= 1'b0;
            irq_pending  <= 1'b0;
            epc          <= '0;
            cause        <= CAUSE_NONE;
            double_fault <= 1'b0;
            exc_count    <= '0;
        end else begin
            irq_q <= bus.irq;

            // A fresh rising edge wins over the clear from taking the interrupt,
            // so an edge arriving in the take cycle is not lost.
            if (irq_rise)
                irq_pending <= 1'b1;
            else if (xadr)
                irq_pending <= 1'b0;

            if ((illop || xadr) && (exc_count != '1))
                exc_count <= exc_count + 16'd1;

            case (state)
                NORMAL: begin
                    if (illop) begin
                        state <= HANDLER;
                        epc   <= bus.pc_cur + 32'd4;
                        cause <= CAUSE_ILL;
                    end else if (xadr) begin
                        state <= HANDLER;
                        epc   <= bus.pc_next;
                        cause <= CAUSE_IRQ;
                    end else if (eret_retire) begin
                        cause <= CAUSE_NONE;
                    end
                end
                HANDLER: begin
                    if (illop) begin
                        double_fault <= 1'b1;
                    end else if (eret_retire) begin
                        state <= NORMAL;
                        cause <= CAUSE_NONE;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

    assign bus.illop        = illop;
    assign bus.xadr         = xadr;
    assign bus.epc          = epc;
    assign bus.cause        = cause;
    assign bus.irq_pending  = irq_pending;
    assign bus.in_handler   = (state == HANDLER);
    assign bus.double_fault = double_fault;
    assign bus.exc_count    = exc_count;
endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-003 instr_done  input  1  current instruction retires this cycle, so the PC register loads this cycle.
REQ-004 illegal  input  1  decoder flags the retiring opcode as illegal; valid only with instr_done.
REQ-005 eret  input  1  retiring instruction is return-from-exception; valid only with instr_done.
REQ-006 irq  input  1  external interrupt request, level, synchronous to clk.
REQ-007 pc_cur  input  32  address of the retiring instruction; bit 31 = kernel mode.
REQ-008 pc_next  input  32  PC value that would be loaded absent an exception.
REQ-009 illop  output  1  to PC register: load illegal-op vector 0x80000004 this edge.
REQ-010 xadr  output  1  to PC register: load interrupt vector 0x80000008 this edge.
REQ-011 epc  output  32  saved return address for the handler.
REQ-012 cause  output  2  00 none, 01 illegal op, 10 interrupt.
REQ-013 irq_pending  output  1  latched interrupt not yet taken.
REQ-014 in_handler  output  1  FSM is in HANDLER state.
REQ-015 double_fault  output  1  sticky: illegal op retired while in HANDLER.
REQ-016 exc_count  output  16  count of exceptions taken, saturating.

Function
REQ-017 illop SHALL be combinational: instr_done & illegal.
REQ-018 xadr SHALL be combinational: instr_done & !illegal & !eret & irq_pending & !pc_cur[31] & !in_handler.
REQ-019 illop and xadr SHALL never be high together; illop has priority.
REQ-020 irq_pending SHALL be set on the cycle after a 0->1 transition of irq is sampled, using a registered copy of irq.
REQ-021 irq_pending SHALL be cleared on the edge where xadr=1; a new rising irq edge in that same cycle SHALL leave it set.
REQ-022 Repeated irq edges while irq_pending=1 SHALL collapse into a single pending request.
REQ-023 The FSM SHALL have two states: NORMAL and HANDLER; in_handler = (state==HANDLER).
REQ-024 NORMAL->HANDLER SHALL occur on an edge with illop=1 or xadr=1.
REQ-025 HANDLER->NORMAL SHALL occur on an edge with instr_done & eret & !illegal.
REQ-026 On illop in NORMAL: epc <= pc_cur + 4 (mod 2^32), cause <= 01.
REQ-027 On xadr: epc <= pc_next, cause <= 10.
REQ-028 On illop in HANDLER: double_fault <= 1; state stays HANDLER; epc and cause unchanged.
REQ-029 On eret retire: cause <= 00; epc unchanged.
REQ-030 exc_count SHALL increment on every edge with illop|xadr and hold at 0xFFFF.
REQ-031 A pending interrupt SHALL stay pending through HANDLER and kernel-mode code, and SHALL be taken at the first eligible user-mode retire after eret.

Reset
REQ-032 On a reset edge: state=NORMAL; irq_pending=0; irq history register=0; epc=0; cause=00; double_fault=0; exc_count=0.
REQ-033 illop and xadr SHALL be 0 whenever reset is high, regardless of other inputs.
REQ-034 Reset asserted mid-HANDLER SHALL return the block to NORMAL on that edge; a pending irq is lost.

Verification
REQ-035 Reset, then pc_cur=0x00000010, instr_done=1, illegal=1 -> illop=1 that cycle; next cycle epc=0x00000014, cause=01, in_handler=1, exc_count=1.
REQ-036 irq 0->1 while in user mode, then instr_done=1 with pc_next=0x00000024 -> xadr=1; next cycle epc=0x00000024, cause=10, irq_pending=0.
REQ-037 irq edge while pc_cur=0x80000100 -> xadr=0 and irq_pending stays 1; after eret and a user-mode retire -> xadr=1.
REQ-038 In HANDLER, illegal retire -> illop=1, double_fault=1, epc unchanged; illegal=1 together with irq_pending=1 -> illop=1, xadr=0.
REQ-039 pc_cur=0xFFFFFFFC illegal -> epc=0x00000000; 65536 exceptions -> exc_count=0xFFFF.
REQ-040 Assert reset during HANDLER with irq_pending=1 -> next cycle in_handler=0, irq_pending=0, all outputs at reset values.
